// File: rtl/fetch_queue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pipe
// Description : Instruction-fetch front end. Owns the fetch PC, a loadable
//               synchronous instruction memory and a QDEPTH-entry prefetch
//               queue that hands {instruction, PC} pairs to decode.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   load_mode             : suspends fetch issue while the memory is loaded
//   we/wr_addr/wr_din     : instruction-memory write port (always active)
//   resetpc               : PC := RESET_PC, flush queue and in-flight read
//   redirect/redirect_pc  : taken branch/jump, flush and refetch from target
//   out_ready             : decode accepts the queue head
//   out_valid/instr/pc    : queue head (instr/pc read as zero when empty)
//   fetch_pc              : next PC to be issued
//   q_count               : entries currently queued
//   misalign_err          : one-cycle pulse after a misaligned redirect
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_queue_pipe #(
    parameter int                XLEN     = 32,
    parameter int                IMEM_AW  = 9,
    parameter int                QDEPTH   = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_mode,
    input  logic                          we,
    input  logic [IMEM_AW-1:0]            wr_addr,
    input  logic [31:0]                   wr_din,
    input  logic                          resetpc,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [31:0]                   out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               fetch_pc,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count,
    output logic                          misalign_err
);

    localparam int c_QCW   = $clog2(QDEPTH+1);
    localparam int c_PW    = $clog2(QDEPTH);
    localparam int c_WORDS = 1 << IMEM_AW;

    localparam logic [c_QCW:0]   c_QDEPTH = (c_QCW+1)'(QDEPTH);
    localparam logic [c_QCW-1:0] c_CNT1   = c_QCW'(1);
    localparam logic [c_PW-1:0]  c_PTR1   = c_PW'(1);
    localparam logic [XLEN-1:0]  c_PC_INC = XLEN'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        r_mem [0:c_WORDS-1];
    logic [31:0]        r_rdata;
    logic               r_inflight;
    logic [XLEN-1:0]    r_inflight_pc;
    logic [XLEN-1:0]    r_fetch_pc;
    logic [31:0]        r_q_instr [0:QDEPTH-1];
    logic [XLEN-1:0]    r_q_pc    [0:QDEPTH-1];
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_QCW-1:0]   r_count;
    logic               r_misalign;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic               w_flush;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [c_QCW:0]     w_credit_used;
    logic [IMEM_AW-1:0] w_rd_idx;

    assign w_flush       = resetpc | redirect;
    // Entries queued plus the read still in the memory pipeline must leave
    // room, so a returning read always has a free slot even without a pop.
    assign w_credit_used = {1'b0, r_count} + {{c_QCW{1'b0}}, r_inflight};
    assign w_issue       = !load_mode && !w_flush && (w_credit_used < c_QDEPTH);
    // A read returning in a flush cycle belongs to the abandoned path.
    assign w_push        = r_inflight && !w_flush;
    assign w_pop         = out_valid && out_ready && !w_flush;
    // Word index taken straight from the PC, so fetch wraps modulo memory size.
    assign w_rd_idx      = r_fetch_pc[IMEM_AW+1:2];

    // ------------------------------------------------------------------
    // Instruction memory: write port always live, 1-cycle synchronous read.
    // Non-blocking update gives old data on read-during-write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_din;
        end
        if (w_issue) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // resetpc outranks redirect, so a shadowed redirect raises no error
            r_misalign <= redirect && !resetpc && (redirect_pc[1:0] != 2'b00);
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
            if (resetpc) begin
                r_fetch_pc <= RESET_PC;
            end else if (redirect) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + c_PC_INC;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch queue (circular buffer, power-of-two depth)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= r_rdata;
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid    = (r_count != '0);
    assign out_instr    = out_valid ? r_q_instr[r_rd_ptr] : 32'd0;
    assign out_pc       = out_valid ? r_q_pc[r_rd_ptr]    : '0;
    assign fetch_pc     = r_fetch_pc;
    assign q_count      = r_count;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_pipe
// Description : Directed self-checking bench for fetch_queue_pipe. Memory
//               words 0..7 hold 0x100+i and word 511 holds 0x1FF.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_mode;
    logic        we;
    logic [8:0]  wr_addr;
    logic [31:0] wr_din;
    logic        resetpc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_pc;
    logic [2:0]  q_count;
    logic        misalign_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue_pipe #(
        .XLEN     (32),
        .IMEM_AW  (9),
        .QDEPTH   (4),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .load_mode    (load_mode),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_din       (wr_din),
        .resetpc      (resetpc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .fetch_pc     (fetch_pc),
        .q_count      (q_count),
        .misalign_err (misalign_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; load_mode = 1'b0; we = 1'b0; wr_addr = '0; wr_din = '0;
        resetpc = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid",    64'(out_valid),    64'd0);
        chk("rst_instr",    64'(out_instr),    64'd0);
        chk("rst_pc",       64'(out_pc),       64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc),     64'd0);
        chk("rst_qcount",   64'(q_count),      64'd0);
        chk("rst_misalign", 64'(misalign_err), 64'd0);

        // Load memory with fetch suspended
        reset = 1'b0; load_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wr_addr = 9'(i); wr_din = 32'h100 + 32'(i);
            tick();
        end
        wr_addr = 9'd511; wr_din = 32'h1FF;
        tick();
        we = 1'b0;
        chk("load_no_issue_pc", 64'(fetch_pc), 64'd0);
        chk("load_no_issue_q",  64'(q_count),  64'd0);

        resetpc = 1'b1; tick(); resetpc = 1'b0;
        load_mode = 1'b0; out_ready = 1'b1;

        // First issue happens now; head valid two edges later
        tick();
        chk("first_not_yet", 64'(out_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_pc",    64'(out_pc),    64'(4*k));
            chk("stream_instr", 64'(out_instr), 64'(32'h100 + 32'(k)));
            tick();
        end

        // Stall: fill queue from a fresh PC
        out_ready = 1'b0; resetpc = 1'b1; tick(); resetpc = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("stall_qcount",   64'(q_count),  64'd4);
        chk("stall_fetch_pc", 64'(fetch_pc), 64'h10);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_pc",    64'(out_pc),    64'(4*k));
            chk("drain_instr", 64'(out_instr), 64'(32'h100 + 32'(k)));
            tick();
        end

        // Redirect with 3 queued entries and one read in flight
        out_ready = 1'b0; resetpc = 1'b1; tick(); resetpc = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_redir_qcount", 64'(q_count), 64'd3);
        redirect = 1'b1; redirect_pc = 32'h14; out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        chk("redir_qcount",   64'(q_count),      64'd0);
        chk("redir_fetch_pc", 64'(fetch_pc),     64'h14);
        chk("redir_no_mis",   64'(misalign_err), 64'd0);
        chk("redir_t1_valid", 64'(out_valid),    64'd0);
        tick();
        chk("redir_t2_valid", 64'(out_valid),    64'd0);
        tick();
        chk("redir_t3_valid", 64'(out_valid),    64'd1);
        chk("redir_t3_pc",    64'(out_pc),       64'h14);
        chk("redir_t3_instr", 64'(out_instr),    64'h105);

        // Misaligned redirect
        redirect = 1'b1; redirect_pc = 32'h16;
        tick();
        redirect = 1'b0;
        chk("mis_pulse",    64'(misalign_err), 64'd1);
        chk("mis_fetch_pc", 64'(fetch_pc),     64'h14);
        tick();
        chk("mis_clear",    64'(misalign_err), 64'd0);
        tick();
        chk("mis_pc",       64'(out_pc),       64'h14);
        chk("mis_instr",    64'(out_instr),    64'h105);

        // redirect + resetpc + pop together: resetpc wins
        chk("pre_both_valid", 64'(out_valid), 64'd1);
        redirect = 1'b1; resetpc = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; resetpc = 1'b0;
        chk("both_qcount",   64'(q_count),  64'd0);
        chk("both_fetch_pc", 64'(fetch_pc), 64'h0);
        tick(); tick();
        chk("both_valid", 64'(out_valid), 64'd1);
        chk("both_pc0",   64'(out_pc),    64'h0);
        chk("both_instr0",64'(out_instr), 64'h100);
        tick();
        chk("both_pc1",   64'(out_pc),    64'h4);

        // Index wrap from the last memory word
        redirect = 1'b1; redirect_pc = 32'h7FC;
        tick();
        redirect = 1'b0;
        tick(); tick();
        chk("wrap_pc_last",    64'(out_pc),    64'h7FC);
        chk("wrap_instr_last", 64'(out_instr), 64'h1FF);
        tick();
        chk("wrap_pc_next",    64'(out_pc),    64'h800);
        chk("wrap_instr_next", 64'(out_instr), 64'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_pipe.md
# fetch_queue_pipe

Parametrised instruction-fetch front end for the pipelined core: owns the fetch PC, a loadable synchronous instruction memory, and a QDEPTH-entry prefetch queue feeding the decode stage with {instruction, PC} pairs. Supports a memory loader port, a PC reset after loading, and branch/jump redirect with full flush of queued and in-flight fetches. Sits between the branch-resolution logic (redirect source) and the instruction decoder / immediate generator (queue consumer).

## Interface
- XLEN, 32, PC width in bits
- IMEM_AW, 9, instruction-memory word-address width (2**IMEM_AW words of 32 bits)
- QDEPTH, 4, prefetch queue depth (power of two, >= 2)
- RESET_PC, 0, PC value loaded on reset and on resetpc

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears queue, in-flight read, PC
- load_mode  in  1  suspends fetch issue while high (memory loading)
- we  in  1  instruction-memory write enable
- wr_addr  in  IMEM_AW  write word address
- wr_din  in  32  write data
- resetpc  in  1  PC := RESET_PC, flush queue and in-flight read
- redirect  in  1  branch/jump taken; flush and refetch from redirect_pc
- redirect_pc  in  XLEN  redirect target (byte address)
- out_ready  in  1  decode accepts head entry (driven as ~stall)
- out_valid  out  1  queue head valid
- out_instr  out  32  head instruction; 0 when out_valid=0
- out_pc  out  XLEN  PC of head instruction; 0 when out_valid=0
- fetch_pc  out  XLEN  next PC to be issued
- q_count  out  $clog2(QDEPTH+1)  entries currently queued
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation
- Memory: write port (we, wr_addr, wr_din) always active; read is synchronous, 1-cycle latency, index = fetch_pc[IMEM_AW+1:2] (PC wraps modulo memory size). Read-during-write to same word returns old data.
- Issue condition: !load_mode && !redirect && !resetpc && (q_count + inflight) < QDEPTH, inflight = read issued last cycle and not killed. On issue: read fetch_pc, record it as inflight PC, fetch_pc += 4 (wraps at 2**XLEN).
- Return: cycle after issue, if not killed, {rdata, inflight PC} pushed at queue tail.
- Pop: out_valid && out_ready removes head. Push and pop in the same cycle leave q_count unchanged.
- Redirect: queue emptied, inflight killed, fetch_pc := {redirect_pc[XLEN-1:2], 2'b00}; misalign_err pulses if redirect_pc[1:0] != 0. Pop in the same cycle is ignored (flush wins).
- resetpc: as redirect with target RESET_PC; takes priority over redirect. reset takes priority over both.
- load_mode high: no new issue; inflight read still returns; queued entries remain poppable.
- Queue never overflows (credit check); pop on empty impossible (gated by out_valid).

## Timing
- Reset values: out_valid=0, out_instr=0, out_pc=0, fetch_pc=RESET_PC, q_count=0, misalign_err=0, inflight=0.
- First fetch: issue in first cycle with reset low; out_valid=1 two cycles later.
- Issue-to-visible latency: 2 cycles (read cycle, push cycle, then head valid).
- Redirect at cycle t: fetch_pc updated at edge ending t; issue at t+1; out_valid=1 at t+3 with out_pc = aligned target. out_valid=0 during t+1..t+2.
- Steady state with out_ready=1: one instruction per cycle, consecutive out_pc +4.
- Stall (out_ready=0): queue fills to QDEPTH then issue halts; no entry lost or duplicated; on release, drains in order at 1/cycle.
- out_instr/out_pc are combinational from queue head.

## Test plan
- Load words 0..7 with 0x100+i via we in load_mode, pulse resetpc, drop load_mode, out_ready=1 -> out_valid rises 2 cycles after first issue; out_pc 0,4,8,... with out_instr 0x100,0x101,... one per cycle.
- Hold out_ready=0 for 10 cycles -> q_count saturates at 4, fetch_pc stops at 16; release -> PCs 0,4,8,12,16 in order, no gaps or repeats.
- Redirect to 0x14 while queue holds 3 entries and a read is inflight -> q_count=0 next cycle; next out_pc=0x14, instr=0x105, three cycles after redirect.
- Redirect to 0x16 -> misalign_err pulses 1 cycle, refetch from 0x14.
- redirect and resetpc in same cycle, with simultaneous pop -> fetch resumes at RESET_PC, popped entry discarded, q_count=0.
- fetch_pc at last word (0x7FC, IMEM_AW=9) -> next out_instr from word 0 with out_pc=0x800 (index wrap).
